// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and BCD status outputs of the countdown timer.
interface countdown_timer_if;
    logic       load;
    logic [7:0] preset;
    logic       start;
    logic       pause;
    logic [7:0] time_reading;
    logic       running;
    logic       expired;
    modport master (output load, preset, start, pause, input time_reading, running, expired);
    modport slave (input load, preset, start, pause, output time_reading, running, expired);
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD countdown ticking once every CLK_FREQ cycles.
module countdown_timer #(
    parameter int CLK_FREQ = 100000000
) (
    input logic               clk,
    input logic               init_regs,
    countdown_timer_if.slave  bus
);
    localparam int DW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, EXPIRED = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    rd_q, rd_d, dec, clamped;
    logic          running_q, running_d, expired_q, expired_d;
    always_comb begin
        clamped = {(bus.preset[7:4] > 4'd9) ? 4'd9 : bus.preset[7:4],
                   (bus.preset[3:0] > 4'd9) ? 4'd9 : bus.preset[3:0]};
        dec = (rd_q[3:0] == 4'd0) ? {rd_q[7:4] - 4'd1, 4'd9} : {rd_q[7:4], rd_q[3:0] - 4'd1};
        state_d = state_q;
        div_d = div_q;
        rd_d = rd_q;
        if (init_regs) begin
            state_d = IDLE;
            div_d = '0;
            rd_d = 8'h00;
        end else if (bus.load) begin
            state_d = IDLE;
            div_d = '0;
            rd_d = clamped;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (div_q == DW'(CLK_FREQ - 1)) begin
                        // The edge that writes 00 also enters EXPIRED, so expired rises with 00.
                        div_d = '0;
                        rd_d = (rd_q == 8'h00) ? 8'h00 : dec;
                        state_d = (rd_q <= 8'h01) ? EXPIRED : RUN;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                IDLE, PAUSED: begin
                    if (bus.start && !(state_q == PAUSED && bus.pause))
                        state_d = (rd_q != 8'h00) ? RUN : EXPIRED;
                end
                default: rd_d = 8'h00;
            endcase
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end
    always_ff @(posedge clk) begin
        state_q <= state_d;
        div_q <= div_d;
        rd_q <= rd_d;
        running_q <= running_d;
        expired_q <= expired_d;
    end
    assign bus.time_reading = rd_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus with an integer-seconds reference model checked every cycle.
module tb_countdown_timer;
    localparam int F = 4;
    logic clk = 1'b0;
    logic init_regs = 1'b0;
    int tests = 0, fails = 0;
    countdown_timer_if ifc();
    countdown_timer #(.CLK_FREQ(F)) dut (.clk(clk), .init_regs(init_regs), .bus(ifc.slave));
    always #5 clk = ~clk;
    // Reference: remaining seconds as an integer, phase within the current second, and mode.
    int m_val = 0, m_ph = 0, m_mode = 0;
    bit m_valid = 1'b0;
    function automatic logic [7:0] to_bcd(int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction
    function automatic int dig(logic [3:0] d);
        return (d > 9) ? 9 : int'(d);
    endfunction
    always @(posedge clk) begin
        if (init_regs) begin
            m_valid = 1'b1; m_mode = 0; m_val = 0; m_ph = 0;
        end else if (ifc.load) begin
            m_val = dig(ifc.preset[7:4]) * 10 + dig(ifc.preset[3:0]); m_ph = 0; m_mode = 0;
        end else if (m_mode == 1 && ifc.pause) begin
            m_mode = 2;
        end else if (m_mode == 1) begin
            m_ph = m_ph + 1;
            if (m_ph == F) begin
                m_ph = 0;
                if (m_val > 0) m_val = m_val - 1;
                if (m_val == 0) m_mode = 3;
            end
        end else if (ifc.start && (m_mode == 0 || (m_mode == 2 && !ifc.pause))) begin
            m_mode = (m_val != 0) ? 1 : 3;
        end
    end
    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if (ifc.time_reading !== to_bcd(m_val) || ifc.running !== (m_mode == 1) || ifc.expired !== (m_mode == 3)) begin
                fails++;
                $display("FAIL model t=%0t: got rd=%h run=%b exp=%b expected rd=%h run=%b exp=%b", $time,
                         ifc.time_reading, ifc.running, ifc.expired, to_bcd(m_val), m_mode == 1, m_mode == 3);
            end
        end
    end
    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_load(logic [7:0] p);
        ifc.preset = p; ifc.load = 1'b1; cyc(1); ifc.load = 1'b0;
    endtask
    task automatic do_start();
        ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    endtask
    int n;
    initial begin
        ifc.load = 1'b0; ifc.start = 1'b0; ifc.pause = 1'b0; ifc.preset = 8'h00;
        init_regs = 1'b1; cyc(2); init_regs = 1'b0;
        chk("reset_rd", ifc.time_reading, 8'h00);
        chk("reset_run", ifc.running, 0);
        chk("reset_exp", ifc.expired, 0);
        do_load(8'h12);
        chk("load_12", ifc.time_reading, 8'h12);
        do_start();
        chk("start_run", ifc.running, 1);
        cyc(3);
        chk("hold_12", ifc.time_reading, 8'h12);
        cyc(1);
        chk("first_tick", ifc.time_reading, 8'h11);
        n = 4;
        while (!ifc.expired && n < 200) begin cyc(1); n++; end
        chk("expire_cycles", n, 48);
        chk("expire_rd", ifc.time_reading, 8'h00);
        chk("expire_run", ifc.running, 0);
        do_load(8'h20); do_start(); cyc(3);
        chk("pre_borrow", ifc.time_reading, 8'h20);
        cyc(1);
        chk("borrow", ifc.time_reading, 8'h19);
        do_load(8'h20); do_start(); cyc(2);
        ifc.pause = 1'b1; cyc(1); ifc.pause = 1'b0;
        cyc(10);
        chk("paused_rd", ifc.time_reading, 8'h20);
        chk("paused_run", ifc.running, 0);
        do_start();
        chk("resume_rd", ifc.time_reading, 8'h20);
        cyc(1);
        chk("resume_hold", ifc.time_reading, 8'h20);
        cyc(1);
        chk("resume_tick", ifc.time_reading, 8'h19);
        do_load(8'hAF);
        chk("clamp_af", ifc.time_reading, 8'h99);
        do_load(8'h3C);
        chk("clamp_3c", ifc.time_reading, 8'h39);
        ifc.pause = 1'b1; cyc(1); ifc.pause = 1'b0;
        chk("idle_pause", ifc.running, 0);
        do_load(8'h00); do_start();
        chk("zero_exp", ifc.expired, 1);
        do_start(); cyc(3);
        chk("exp_hold_rd", ifc.time_reading, 8'h00);
        chk("exp_hold", ifc.expired, 1);
        do_load(8'h12); do_start(); cyc(3);
        init_regs = 1'b1; ifc.start = 1'b1; cyc(1); init_regs = 1'b0; ifc.start = 1'b0;
        chk("rst_tick_rd", ifc.time_reading, 8'h00);
        chk("rst_tick_run", ifc.running, 0);
        chk("rst_tick_exp", ifc.expired, 0);
        do_load(8'h00); do_start();
        ifc.preset = 8'h05; ifc.load = 1'b1; ifc.start = 1'b1; cyc(1); ifc.load = 1'b0; ifc.start = 1'b0;
        chk("ldst_rd", ifc.time_reading, 8'h05);
        chk("ldst_exp", ifc.expired, 0);
        chk("ldst_run", ifc.running, 0);
        do_start();
        chk("ldst_start", ifc.running, 1);
        ifc.pause = 1'b1; ifc.start = 1'b1; cyc(1);
        chk("ps_run", ifc.running, 0);
        cyc(1);
        chk("ps_paused", ifc.running, 0);
        ifc.pause = 1'b0; cyc(1); ifc.start = 1'b0;
        chk("ps_resume", ifc.running, 1);
        cyc(25);
        chk("final_exp", ifc.expired, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
